ed25519_encode: RTL and testbench
=================================

Name: ed25519_encode

Overview:
- Converts an extended-coordinate Ed25519 point (X:Y:Z:T) to affine (x, y) and the 256-bit RFC 8032 compressed encoding.
- Sits downstream of the ed25519 scalar-multiply core and consumes its x3/y3/z3 outputs. This is the output end of the point pipeline.
- Computes Z^-1 = Z^(q-2) mod q by square-and-multiply on a shared sequential modular multiplier, then forms x = X·Z^-1 and y = Y·Z^-1.
- Encoding: enc = {x[0], y[254:0]}.

Parameters:
- W, 257, operand width (matches the codebase point width `b`).
- MUL_CYCLES, 256, cycles per modmul from issue to result (1 load + 255 bit-serial iterations).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- x  input  W  extended X; value must be < q.
- y  input  W  extended Y; value must be < q.
- z  input  W  extended Z; value must be < q.
- t  input  W  extended T; accepted for interface symmetry, unused.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when results are valid.
- xa  output  W  affine x, in [0, q-1].
- ya  output  W  affine y, in [0, q-1].
- enc  output  256  compressed point.
- err  output  1  Z was zero; only present with the optional feature, otherwise tied 0.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, err = 0; xa, ya, enc = 0; internal registers cleared. Reset mid-operation aborts immediately, and no done is produced.
- Start: start=1 in IDLE latches x, y, z into registers and moves to INV. start while busy is ignored and does not restart.
- FSM states: IDLE -> INV_SQ <-> INV_MUL -> MUL_X -> MUL_Y -> FIN -> IDLE.
- INV: acc = 1, exponent e = q-2 = 2^255-21, scanned from bit 254 down to bit 0.
  - Each bit: acc = acc² (INV_SQ). If the bit is 1, then acc = acc·z (INV_MUL).
  - Bits 254..5 are 1; bits 4..0 are 01011. This gives 255 squarings and 253 multiplies.
- MUL_X computes xa = X·acc; MUL_Y computes ya = Y·acc.
- Each multiply occupies exactly MUL_CYCLES+1 = 257 cycles including the issue cycle. Total is 510 multiplies.
- Latency is data-independent: done asserts exactly 131072 clocks after the rising edge that samples start.
- FIN: registers xa, ya, enc = {xa[0], ya[254:0]}; pulses done for 1 cycle; returns to IDLE.
- Output hold: xa/ya/enc hold until the next accepted start and change only in FIN.
- Arithmetic: all products fully reduced mod q, with results < q. Reduction inside the modmul uses 2^255 ≡ 19 (mod q) and a final conditional subtract.
- Inputs ≥ q: result unspecified, but latency and handshake are unchanged.
- start in the same cycle as done/FIN: ignored, because the FSM is not yet in IDLE.

Optional Feature:
- Macro: ED25519_ENC_ZERO_CHECK_EN.
- Defined: in the cycle after start is accepted, if z == 0:
  - err=1, xa=ya=enc=0;
  - done pulses 2 cycles after start;
  - err holds until the next accepted start, which clears it.
  - For non-zero z, behaviour is as above.
- Undefined: no check; err tied 0. z=0 yields xa=ya=0, enc=0 at normal latency.

Decomposition:
- Package ed25519_pkg:
  - B=257;
  - Q (q = 2^255-19);
  - L (group order);
  - Q_MINUS_2;
  - encode FSM state enum;
  - LATENCY=131072.
- Sub-module ed25519_modmul:
  - bit-serial interleaved modular multiplier;
  - ports clk, rst_n, go, a, b, done, p;
  - fixed MUL_CYCLES latency.
- The top level owns the FSM, exponent bit counter (8 bits, 254→0) and operand muxing.

Test Plan:
- Z=1 point: x=15112221349535400772501151409588531511454012693041857206046113283949847762202, y=46316835694926478169428394003475163141307993866256225615783033603165251855960 -> xa=x, ya=y, enc=y (x even so bit255=0), done exactly 131072 cycles after start.
- Same point scaled: X=2x mod q, Y=2y mod q, Z=2 -> identical xa/ya/enc to the Z=1 case.
- Identity (0:1:1) -> xa=0, ya=1, enc=1. Then (q-1:1:1) -> xa=q-1, enc={1'b0, 1} (q-1 even, so sign bit 0).
- start pulsed again at cycle 1000 of an operation -> ignored; one done at 131072; results match the first request.
- rst_n low at cycle 5000 -> busy=0 and outputs=0 immediately; no done follows; a new start afterwards completes correctly.
- With ED25519_ENC_ZERO_CHECK_EN: z=0 -> done at +2 cycles, err=1, enc=0. A following valid start clears err.

Source files
------------

// File: rtl/ed25519_pkg.sv
// Shared constants, field parameters and encode FSM state type for the
// Ed25519 point-output pipeline.
package ed25519_pkg;

    localparam int unsigned B          = 257;
    localparam int unsigned MUL_CYC    = 256;
    localparam int unsigned LATENCY    = 131072;

    // q = 2^255 - 19
    localparam logic [B-1:0] Q         = (B'(1) << 255) - B'(19);
    localparam logic [B-1:0] Q_MINUS_2 = Q - B'(2);
    // Prime order of the base-point subgroup
    localparam logic [B-1:0] L         = (B'(1) << 252) + B'(128'h14def9dea2f79cd65812631a5cf5d3ed);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INV_SQ,
        ST_INV_MUL,
        ST_MUL_X,
        ST_MUL_Y,
        ST_FIN
    } enc_state_t;

endpackage

// File: rtl/ed25519_modmul.sv
// Bit-serial interleaved multiplier mod q: one load cycle, then one operand
// bit per cycle (MSB first), result and done pulse MUL_CYCLES after go.
module ed25519_modmul
    import ed25519_pkg::*;
#(
    parameter int unsigned W          = B,
    parameter int unsigned MUL_CYCLES = MUL_CYC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         done,
    output logic [W-1:0] p
);

    localparam int unsigned ITERS = MUL_CYCLES - 1;
    localparam int unsigned CW    = $clog2(MUL_CYCLES);
    localparam int unsigned SW    = W + 1;
    localparam logic [SW-1:0] QS  = SW'(Q);

    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [CW-1:0] cnt;
    logic          run;
    logic [SW-1:0] sum_c;
    logic [SW-1:0] fold_c;
    logic [W-1:0]  p_nxt_c;
    logic          unused_ok;

    assign unused_ok = a_r[W-1];

    // p <- 2p + bit*b, folded with 2^255 = 19 then one conditional subtract
    always_comb begin
        sum_c   = {p, 1'b0} + (a_r[ITERS-1] ? SW'(b_r) : '0);
        fold_c  = SW'(sum_c[254:0]) + SW'(sum_c[SW-1:255]) * SW'(19);
        p_nxt_c = W'((fold_c >= QS) ? (fold_c - QS) : fold_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r  <= '0;
            b_r  <= '0;
            p    <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (go) begin
                a_r <= a;
                b_r <= b;
                p   <= '0;
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                p   <= p_nxt_c;
                a_r <= {a_r[W-2:0], 1'b0};
                cnt <= cnt + CW'(1);
                if (cnt == CW'(ITERS - 1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ed25519_encode.sv
// Extended (X:Y:Z:T) to affine (x, y) plus RFC 8032 compressed encoding via
// Fermat inversion. Optional zero-Z detection: ED25519_ENC_ZERO_CHECK_EN.
module ed25519_encode
    import ed25519_pkg::*;
#(
    parameter int unsigned W          = B,
    parameter int unsigned MUL_CYCLES = MUL_CYC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic [W-1:0] z,
    input  logic [W-1:0] t,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] xa,
    output logic [W-1:0] ya,
    output logic [255:0] enc,
    output logic         err
);

    localparam int unsigned IW  = $clog2(W);
    localparam logic [W-1:0] EXP = W'(Q_MINUS_2);

    enc_state_t    state, state_nx;
    logic [W-1:0]  x_r, y_r, z_r, acc;
    logic [7:0]    bit_idx;
    logic          issued;
    logic          prep;
    logic          exp_bit_c;
    logic          mul_go_c;
    logic [W-1:0]  mul_a_c, mul_b_c;
    logic          mul_done;
    logic [W-1:0]  mul_p;
    logic          zero_hit_c;
    logic          unused_ok;

    assign unused_ok = ^t;
    assign exp_bit_c = EXP[IW'(bit_idx)];

`ifdef ED25519_ENC_ZERO_CHECK_EN
    logic err_q;
    assign err        = err_q;
    assign zero_hit_c = (state == ST_INV_SQ) && prep && (z_r == '0);
`else
    assign err        = 1'b0;
    assign zero_hit_c = 1'b0;
`endif

    ed25519_modmul #(.W(W), .MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .go    (mul_go_c),
        .a     (mul_a_c),
        .b     (mul_b_c),
        .done  (mul_done),
        .p     (mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Next state and multiplier operand selection; one multiply per state visit
    always_comb begin
        state_nx = state;
        mul_go_c = 1'b0;
        mul_a_c  = acc;
        mul_b_c  = acc;
        case (state)
            ST_IDLE: begin
                if (start) state_nx = ST_INV_SQ;
            end
            ST_INV_SQ: begin
                mul_go_c = !issued && !prep;
                if (zero_hit_c) begin
                    state_nx = ST_FIN;
                    mul_go_c = 1'b0;
                end else if (mul_done) begin
                    if (exp_bit_c)              state_nx = ST_INV_MUL;
                    else if (bit_idx == 8'd0)   state_nx = ST_MUL_X;
                end
            end
            ST_INV_MUL: begin
                mul_go_c = !issued;
                mul_b_c  = z_r;
                if (mul_done) state_nx = (bit_idx == 8'd0) ? ST_MUL_X : ST_INV_SQ;
            end
            ST_MUL_X: begin
                mul_go_c = !issued;
                mul_a_c  = x_r;
                if (mul_done) state_nx = ST_MUL_Y;
            end
            ST_MUL_Y: begin
                mul_go_c = !issued;
                mul_a_c  = y_r;
                if (mul_done) state_nx = ST_FIN;
            end
            ST_FIN:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r     <= '0;
            y_r     <= '0;
            z_r     <= '0;
            acc     <= '0;
            bit_idx <= '0;
            issued  <= 1'b0;
            prep    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            xa      <= '0;
            ya      <= '0;
            enc     <= '0;
`ifdef ED25519_ENC_ZERO_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            prep <= 1'b0;
            if (state == ST_IDLE && start) begin
                x_r     <= x;
                y_r     <= y;
                z_r     <= z;
                acc     <= W'(1);
                bit_idx <= 8'd254;
                issued  <= 1'b0;
                prep    <= 1'b1;
                busy    <= 1'b1;
`ifdef ED25519_ENC_ZERO_CHECK_EN
                err_q   <= 1'b0;
`endif
            end else begin
                if (zero_hit_c) begin
                    x_r <= '0;
                    y_r <= '0;
`ifdef ED25519_ENC_ZERO_CHECK_EN
                    err_q <= 1'b1;
`endif
                end
                if (mul_go_c) issued <= 1'b1;
                if (mul_done) begin
                    issued <= 1'b0;
                    case (state)
                        ST_INV_SQ: begin
                            acc <= mul_p;
                            if (!exp_bit_c && bit_idx != 8'd0) bit_idx <= bit_idx - 8'd1;
                        end
                        ST_INV_MUL: begin
                            acc <= mul_p;
                            if (bit_idx != 8'd0) bit_idx <= bit_idx - 8'd1;
                        end
                        ST_MUL_X: x_r <= mul_p;
                        ST_MUL_Y: y_r <= mul_p;
                        default: ;
                    endcase
                end
                // Results become visible only here
                if (state == ST_FIN) begin
                    xa   <= x_r;
                    ya   <= y_r;
                    enc  <= {x_r[0], y_r[254:0]};
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ed25519_encode.sv
// Self-checking bench for ed25519_encode: vector table plus reset, restart and
// optional zero-Z sequences, against a wide-integer modular reference model.
module tb_ed25519_encode;

    localparam int LAT = 131072;
    localparam logic [256:0] QQ = (257'(1) << 255) - 257'(19);

    typedef struct {
        logic [256:0] x, y, z;
        logic [256:0] exa, eya;
        logic [255:0] eenc;
        logic         restart;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [256:0] x, y, z, t;
    logic         busy, done, err;
    logic [256:0] xa, ya;
    logic [255:0] enc;

    int errors = 0;
    int checks = 0;
    logic [256:0] hold_xa;
    logic [255:0] hold_enc;
    vec_t tbl[5];

    always #5 clk = ~clk;

    ed25519_encode dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .x(x), .y(y), .z(z), .t(t),
        .busy(busy), .done(done), .xa(xa), .ya(ya), .enc(enc), .err(err)
    );

    function automatic logic [256:0] mmul(input logic [256:0] a, input logic [256:0] b);
        logic [513:0] pr;
        pr = {257'b0, a} * {257'b0, b};
        return 257'(pr % {257'b0, QQ});
    endfunction

    // Right-to-left binary exponentiation
    function automatic logic [256:0] mpow(input logic [256:0] base, input logic [256:0] e);
        logic [256:0] r, sq;
        r  = 257'(1);
        sq = base;
        for (int i = 0; i < 257; i++) begin
            if (e[i]) r = mmul(r, sq);
            sq = mmul(sq, sq);
        end
        return r;
    endfunction

    function automatic logic [256:0] rnd_fe();
        logic [256:0] v;
        v = '0;
        for (int i = 0; i < 8; i++) v = (v << 32) | 257'($urandom);
        return v % QQ;
    endfunction

    task automatic chk(input string name, input logic [256:0] act, input logic [256:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input int exp_lat, input logic exp_err);
        int cyc;
        logic got;
        @(negedge clk);
        x = v.x; y = v.y; z = v.z; t = rnd_fe();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (cyc < LAT + 40 && !got) begin
            @(negedge clk);
            cyc++;
            if (done) got = 1'b1;
            else begin
                if (cyc == 1000) begin
                    chk("busy_mid", 257'(busy), 257'(1));
                    chk("xa_hold", xa, hold_xa);
                    chk("enc_hold", 257'(enc), 257'(hold_enc));
                end
                start = v.restart && (cyc == 1000);
            end
        end
        start = 1'b0;
        chk("latency", 257'(cyc), 257'(exp_lat));
        chk("xa", xa, v.exa);
        chk("ya", ya, v.eya);
        chk("enc", 257'(enc), 257'(v.eenc));
        chk("err", 257'(err), 257'(exp_err));
        @(negedge clk);
        chk("done_pulse", 257'(done), 257'(0));
        chk("busy_end", 257'(busy), 257'(0));
        if (v.restart) begin
            got = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(negedge clk);
                if (done) got = 1'b1;
            end
            chk("no_second_done", 257'(got), 257'(0));
        end
        hold_xa  = v.exa;
        hold_enc = v.eenc;
    endtask

    initial begin
        logic [256:0] bx, by, inv;
        vec_t zv;
        logic seen;

        rst_n = 1'b0; start = 1'b0;
        x = '0; y = '0; z = '0; t = '0;
        hold_xa = '0; hold_enc = '0;

        bx = 257'h216936d3cd6e53fec0a4e231fdd6dc5c692cc7609525a7b2c9562d608f25d51a;
        by = 257'h6666666666666666666666666666666666666666666666666666666666666658;

        tbl[0] = '{x: bx, y: by, z: 257'(1), exa: bx, eya: by, eenc: by[255:0], restart: 1'b0};
        tbl[1] = '{x: mmul(257'(2), bx), y: mmul(257'(2), by), z: 257'(2),
                   exa: bx, eya: by, eenc: by[255:0], restart: 1'b1};
        tbl[2] = '{x: '0, y: 257'(1), z: 257'(1), exa: '0, eya: 257'(1), eenc: 256'(1), restart: 1'b0};
        tbl[3] = '{x: QQ - 257'(1), y: 257'(1), z: 257'(1),
                   exa: QQ - 257'(1), eya: 257'(1), eenc: 256'(1), restart: 1'b0};
        tbl[4].x = rnd_fe(); tbl[4].y = rnd_fe(); tbl[4].z = rnd_fe();
        if (tbl[4].z == '0) tbl[4].z = 257'(7);
        inv = mpow(tbl[4].z, QQ - 257'(2));
        tbl[4].exa = mmul(tbl[4].x, inv);
        tbl[4].eya = mmul(tbl[4].y, inv);
        tbl[4].eenc = {tbl[4].exa[0], tbl[4].eya[254:0]};
        tbl[4].restart = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_busy", 257'(busy), 257'(0));
        chk("rst_done", 257'(done), 257'(0));
        chk("rst_xa", xa, '0);
        chk("rst_enc", 257'(enc), '0);
        chk("rst_err", 257'(err), '0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(tbl[0], LAT, 1'b0);

        // Abort an operation with reset at cycle 5000
        @(negedge clk);
        x = tbl[1].x; y = tbl[1].y; z = tbl[1].z; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("early_done", 257'(seen), 257'(0));
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 257'(busy), 257'(0));
        chk("abort_xa", xa, '0);
        chk("abort_ya", ya, '0);
        chk("abort_enc", 257'(enc), '0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("abort_no_done", 257'(seen), 257'(0));
        hold_xa = '0; hold_enc = '0;

        run_op(tbl[1], LAT, 1'b0);
`ifdef ED25519_ENC_ZERO_CHECK_EN
        zv = '{x: bx, y: by, z: '0, exa: '0, eya: '0, eenc: '0, restart: 1'b0};
        run_op(zv, 2, 1'b1);
`else
        zv = tbl[2];
`endif
        for (int k = 2; k < 5; k++) run_op(tbl[k], LAT, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
